// File: rtl/lvds_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : lvds_video_timing_gen
// Purpose  : Pixel-clock VS/HS/DE/RGB timing generator feeding an LVDS 7:1 TX.
//            Optional built-in test patterns when VTG_PATTERN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module lvds_video_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int DATA_W   = 8
) (
    input  logic              I_pix_clk,
    input  logic              I_rst,
    input  logic              I_en,
`ifdef VTG_PATTERN_EN
    input  logic [2:0]        I_pattern_sel,
`endif
    input  logic [DATA_W-1:0] I_data_r,
    input  logic [DATA_W-1:0] I_data_g,
    input  logic [DATA_W-1:0] I_data_b,
    output logic              O_data_req,
    output logic              O_vs,
    output logic              O_hs,
    output logic              O_de,
    output logic [DATA_W-1:0] O_data_r,
    output logic [DATA_W-1:0] O_data_g,
    output logic [DATA_W-1:0] O_data_b,
    output logic              O_frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic              w_act, w_hs_act, w_vs_act, w_fs;
    logic              w_act_d, w_start_d, w_ext_d;
    logic              req_q;
    logic              act1_q, hs1_q, vs1_q, fs1_q;
    logic              de_q, hs_q, vs_q, fs_q;
    logic [DATA_W-1:0] w_src_r, w_src_g, w_src_b;
    logic [DATA_W-1:0] dr_q, dg_q, db_q;

    always_ff @(posedge I_pix_clk or posedge I_rst) begin
        if (I_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (I_en) state_d = ST_RUN;
            ST_RUN:  if (!I_en && h_q == H_LAST && v_q == V_LAST) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_act    = (state_q == ST_RUN) && (h_q < H_ACT) && (v_q < V_ACT);
        w_hs_act = (h_q >= HS_BEGIN) && (h_q < HS_END);
        w_vs_act = (v_q >= VS_BEGIN) && (v_q < VS_END);
        w_fs     = (state_q == ST_RUN) && (h_q == '0) && (v_q == '0);
    end

    // Counters sit at 0 in IDLE so the first RUN cycle is position (0,0).
    always_comb begin
        h_d = '0;
        v_d = '0;
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
            v_d = v_q;
            if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
        w_act_d   = (state_d == ST_RUN) && (h_d < H_ACT) && (v_d < V_ACT);
        w_start_d = (state_d == ST_RUN) && (h_d == '0) && (v_d == '0);
    end

`ifdef VTG_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [2:0]        pat_q, w_pat_d;
    logic              w_ext, ext1_q;
    logic [2:0]        w_bar;
    logic              w_chk;
    logic [DATA_W-1:0] w_pix_r, w_pix_g, w_pix_b;
    logic [DATA_W-1:0] pix1_r_q, pix1_g_q, pix1_b_q;

    // Selection is latched on the edge that enters (0,0), so it holds for a whole frame.
    always_comb begin
        w_pat_d = w_start_d ? I_pattern_sel : pat_q;
        w_ext_d = (w_pat_d == 3'd0) || (w_pat_d > 3'd4);
        w_ext   = (pat_q == 3'd0) || (pat_q > 3'd4);
        w_bar   = 3'(h_q / HW'(BAR_W));
        w_chk   = 1'((HW + 6)'(h_q) >> 5) ^ 1'((VW + 6)'(v_q) >> 5);
        w_pix_r = '0;
        w_pix_g = '0;
        w_pix_b = '0;
        case (pat_q)
            3'd1: begin
                w_pix_r = {DATA_W{~w_bar[1]}};
                w_pix_g = {DATA_W{~w_bar[2]}};
                w_pix_b = {DATA_W{~w_bar[0]}};
            end
            3'd2: begin
                w_pix_r = DATA_W'(h_q);
                w_pix_g = DATA_W'(h_q);
                w_pix_b = DATA_W'(h_q);
            end
            3'd3: begin
                w_pix_r = '1;
                w_pix_g = '1;
                w_pix_b = '1;
            end
            3'd4: begin
                w_pix_r = {DATA_W{w_chk}};
                w_pix_g = {DATA_W{w_chk}};
                w_pix_b = {DATA_W{w_chk}};
            end
            default: ;
        endcase
        w_src_r = ext1_q ? I_data_r : pix1_r_q;
        w_src_g = ext1_q ? I_data_g : pix1_g_q;
        w_src_b = ext1_q ? I_data_b : pix1_b_q;
    end

    always_ff @(posedge I_pix_clk or posedge I_rst) begin
        if (I_rst) begin
            pat_q    <= '0;
            ext1_q   <= 1'b1;
            pix1_r_q <= '0;
            pix1_g_q <= '0;
            pix1_b_q <= '0;
        end else begin
            pat_q    <= w_pat_d;
            ext1_q   <= w_ext;
            pix1_r_q <= w_pix_r;
            pix1_g_q <= w_pix_g;
            pix1_b_q <= w_pix_b;
        end
    end
`else
    always_comb begin
        w_ext_d = 1'b1;
        w_src_r = I_data_r;
        w_src_g = I_data_g;
        w_src_b = I_data_b;
    end
`endif

    // Request leads DE by two cycles; upstream data arrives in the middle stage.
    always_ff @(posedge I_pix_clk or posedge I_rst) begin
        if (I_rst) begin
            h_q    <= '0;
            v_q    <= '0;
            req_q  <= 1'b0;
            act1_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            fs1_q  <= 1'b0;
            de_q   <= 1'b0;
            hs_q   <= ~HS_ON;
            vs_q   <= ~VS_ON;
            fs_q   <= 1'b0;
            dr_q   <= '0;
            dg_q   <= '0;
            db_q   <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            req_q  <= w_act_d && w_ext_d;
            act1_q <= w_act;
            hs1_q  <= w_hs_act;
            vs1_q  <= w_vs_act;
            fs1_q  <= w_fs;
            de_q   <= act1_q;
            hs_q   <= hs1_q ? HS_ON : ~HS_ON;
            vs_q   <= vs1_q ? VS_ON : ~VS_ON;
            fs_q   <= fs1_q;
            dr_q   <= act1_q ? w_src_r : '0;
            dg_q   <= act1_q ? w_src_g : '0;
            db_q   <= act1_q ? w_src_b : '0;
        end
    end

    assign O_data_req    = req_q;
    assign O_de          = de_q;
    assign O_hs          = hs_q;
    assign O_vs          = vs_q;
    assign O_frame_start = fs_q;
    assign O_data_r      = dr_q;
    assign O_data_g      = dg_q;
    assign O_data_b      = db_q;
endmodule
`default_nettype wire

// File: tb/tb_lvds_video_timing_gen.sv
`default_nettype none
// Testbench for lvds_video_timing_gen: 8/2/2/2 x 4/1/1/1 timing, two polarity builds.
module tb_lvds_video_timing_gen;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst, en;
    logic [2:0] sel;
    logic [DW-1:0] dr, dg, db;
    logic req0, vs0, hs0, de0, fs0;
    logic [DW-1:0] r0, g0, b0;
    logic req1, vs1, hs1, de1, fs1;
    logic [DW-1:0] r1, g1, b1;

    int n_vec = 0;
    int n_err = 0;
    int up_cnt = 0;

    always #5 clk = ~clk;

    lvds_video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .DATA_W(DW)
    ) dut (
        .I_pix_clk(clk), .I_rst(rst), .I_en(en),
`ifdef VTG_PATTERN_EN
        .I_pattern_sel(sel),
`endif
        .I_data_r(dr), .I_data_g(dg), .I_data_b(db),
        .O_data_req(req0), .O_vs(vs0), .O_hs(hs0), .O_de(de0),
        .O_data_r(r0), .O_data_g(g0), .O_data_b(b0), .O_frame_start(fs0)
    );

    lvds_video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .DATA_W(DW)
    ) dut_pol (
        .I_pix_clk(clk), .I_rst(rst), .I_en(en),
`ifdef VTG_PATTERN_EN
        .I_pattern_sel(sel),
`endif
        .I_data_r(dr), .I_data_g(dg), .I_data_b(db),
        .O_data_req(req1), .O_vs(vs1), .O_hs(hs1), .O_de(de1),
        .O_data_r(r1), .O_data_g(g1), .O_data_b(b1), .O_frame_start(fs1)
    );

    typedef struct {
        int   p;
        logic de, hs, vs, fs;
        int   idx;
    } vec_t;

    localparam int NV = 18;
    vec_t vt[NV];

    function automatic vec_t mk(int p, logic de, logic hs, logic vs, logic fs, int idx);
        vec_t v;
        v.p = p; v.de = de; v.hs = hs; v.vs = vs; v.fs = fs; v.idx = idx;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Upstream source: a value becomes valid the cycle after each request.
    initial begin
        logic r;
        dr = '0; dg = '0; db = '0;
        forever begin
            @(negedge clk);
            r = req0;
            @(posedge clk);
            #1;
            if (r) begin
                up_cnt++;
                dr = 8'(up_cnt); dg = 8'(up_cnt); db = 8'(up_cnt);
            end
        end
    end

    // Called at the negedge where the counter sits at (0,0); returns 98 cycles later.
    task automatic run_frame(input int base, input int drop_at, input int sel_at,
                             input int sel_val, input bit use_tbl);
        int nde = 0, nreq = 0, nhs = 0, nvs = 0, ti = 0;
        logic [63:0] e;
        for (int t = 0; t < 98; t++) begin
            if (t == drop_at) en = 1'b0;
            if (t == sel_at) sel = 3'(sel_val);
            if (req0) nreq++;
            if (!hs0) nhs++;
            if (!vs0) nvs++;
            if (de0) begin
                nde++;
                check("pixel", {r0, g0, b0}, {3{8'(base + nde)}});
            end else begin
                check("blank_data", {r0, g0, b0}, 64'd0);
            end
            if (use_tbl && ti < NV && vt[ti].p == t - 2) begin
                e = {vt[ti].de, vt[ti].hs, vt[ti].vs, vt[ti].fs,
                     vt[ti].de ? {3{8'(base + vt[ti].idx)}} : 24'd0};
                check($sformatf("vec_p%0d", vt[ti].p), {de0, hs0, vs0, fs0, r0, g0, b0}, e);
                check($sformatf("pol_p%0d", vt[ti].p), {hs1, vs1}, {~vt[ti].hs, ~vt[ti].vs});
                ti++;
            end
            @(negedge clk);
        end
        check("frame_de_count", nde, 32);
        check("frame_req_count", nreq, 32);
        check("frame_hs_count", nhs, 14);
        check("frame_vs_count", nvs, 14);
    endtask

`ifdef VTG_PATTERN_EN
    task automatic pattern_frame(input int sel_at, input int sel_val);
        logic [23:0] bars [8];
        int nde = 0, nreq = 0;
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        for (int t = 0; t < 98; t++) begin
            if (t == sel_at) sel = 3'(sel_val);
            if (req0) nreq++;
            if (de0) begin
                nde++;
                check("bar_pixel", {r0, g0, b0}, bars[(nde - 1) % 8]);
            end
            @(negedge clk);
        end
        check("bar_de_count", nde, 32);
        check("bar_req_count", nreq, 0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0]  = mk(0,  1, 1, 1, 1, 1);
        vt[1]  = mk(1,  1, 1, 1, 0, 2);
        vt[2]  = mk(7,  1, 1, 1, 0, 8);
        vt[3]  = mk(8,  0, 1, 1, 0, 0);
        vt[4]  = mk(10, 0, 0, 1, 0, 0);
        vt[5]  = mk(11, 0, 0, 1, 0, 0);
        vt[6]  = mk(12, 0, 1, 1, 0, 0);
        vt[7]  = mk(14, 1, 1, 1, 0, 9);
        vt[8]  = mk(24, 0, 0, 1, 0, 0);
        vt[9]  = mk(49, 1, 1, 1, 0, 32);
        vt[10] = mk(50, 0, 1, 1, 0, 0);
        vt[11] = mk(56, 0, 1, 1, 0, 0);
        vt[12] = mk(69, 0, 1, 1, 0, 0);
        vt[13] = mk(70, 0, 1, 0, 0, 0);
        vt[14] = mk(80, 0, 0, 0, 0, 0);
        vt[15] = mk(83, 0, 1, 0, 0, 0);
        vt[16] = mk(84, 0, 1, 1, 0, 0);
        vt[17] = mk(95, 0, 0, 1, 0, 0);

        rst = 1'b1; en = 1'b0; sel = 3'd0;
        repeat (3) @(negedge clk);
        check("reset_out", {req0, de0, hs0, vs0, fs0, r0, g0, b0}, {5'b00110, 24'd0});
        check("reset_pol", {req1, de1, hs1, vs1, fs1}, 5'b00000);

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_req", {req0, de0, hs0, vs0}, 4'b0011);

        en = 1'b1;
        @(negedge clk);
        check("start_req", {req0, de0}, 2'b10);
        run_frame(0, -1, -1, 0, 1'b1);
        run_frame(32, -1, -1, 0, 1'b0);
        run_frame(64, 28, -1, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            check("idle_after_drop", {req0, de0, hs0, vs0, fs0, r0, g0, b0}, {5'b00110, 24'd0});
            @(negedge clk);
        end

        en = 1'b1;
        @(negedge clk);
        check("reen_req", req0, 1'b1);
        run_frame(96, -1, -1, 0, 1'b1);

        repeat (16) @(negedge clk);
        check("pre_reset_de", de0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_reset", {req0, de0, hs0, vs0, fs0, r0, g0, b0}, {5'b00110, 24'd0});
        check("async_reset_pol", {hs1, vs1, de1}, 3'b000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_req", req0, 1'b1);
        run_frame(up_cnt, -1, -1, 0, 1'b1);

`ifdef VTG_PATTERN_EN
        run_frame(up_cnt, -1, 40, 1, 1'b0);
        pattern_frame(40, 0);
        run_frame(up_cnt, -1, -1, 0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
